sreg_ctrl: RTL
==============

SREG_CTRL -- requirements
Module: sreg_ctrl

Interface
REQ-001 SHALL have parameter SREG_IO_ADR, default 6'h3F, the I/O address of SREG.
REQ-002 SHALL have port cp2, input, 1, the core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-004 SHALL have port cpuwait, input, 1, the core stall: holds all state.
REQ-005 SHALL have ports alu_h/s/v/n/z/c_flag_out, input, 1 each, the ALU flag results.
REQ-006 SHALL have port flag_we, input, 6, the per-flag update mask {H,S,V,N,Z,C} from the decoder.
REQ-007 SHALL have ports idc_adiw and idc_sbiw, input, 1 each, the first cycle of a word add/subtract.
REQ-008 SHALL have ports adiw_st and sbiw_st, output, 1 each, the second-cycle strobes sent to the ALU.
REQ-009 SHALL have ports alu_c_flag_in and alu_z_flag_in, output, 1 each, the SREG C and Z fed to the ALU.
REQ-010 SHALL have ports io_adr (input, 6), iowe (input, 1) and dbus_in (input, 8) for I/O writes to SREG.
REQ-011 SHALL have port sreg_out, output, 8, the registered SREG {I,T,H,S,V,N,Z,C}.
REQ-012 SHALL have ports idc_bset and idc_bclr (input, 1 each) and bit_sel (input, 3), which set or clear SREG[bit_sel].
REQ-013 SHALL have ports idc_bst (input, 1) and bst_val (input, 1), which load T.
REQ-014 SHALL have ports irq_ack (input, 1), which clears I, and idc_reti (input, 1), which sets I.
REQ-015 SHALL have port irq_en, output, 1, the interrupt enable qualified for the interrupt controller.

Function
REQ-016 SHALL perform no state change in any cycle with cpuwait=1, except reset.
REQ-017 SHALL load SREG[k] <= ALU flag k in each non-stalled cycle where flag_we[k]=1, for k in {H,S,V,N,Z,C}.
REQ-018 SHALL treat an SREG I/O write as iowe=1 and io_adr==SREG_IO_ADR, loading all 8 bits from dbus_in.
REQ-019 SHALL apply per-bit write priority, highest first: I/O write > bset/bclr > bst (T only) > flag_we; for I: irq_ack > I/O write > bset/bclr > reti.
REQ-020 SHALL let bset win over bclr when both are asserted; the decoder never asserts both, and the bench flags it.
REQ-021 SHALL, on idc_adiw in a non-stalled cycle, assert adiw_st for exactly the next non-stalled cycle; sbiw_st likewise for idc_sbiw.
REQ-022 SHALL let adiw win and suppress sbiw_st when idc_adiw and idc_sbiw arrive together.
REQ-023 SHALL ignore idc_adiw/idc_sbiw arriving while adiw_st or sbiw_st is already high; no back-to-back second cycles.
REQ-024 SHALL hold adiw_st/sbiw_st high across cpuwait, deasserting only after one non-stalled cycle.
REQ-025 SHALL drive alu_c_flag_in = sreg_out[0] and alu_z_flag_in = sreg_out[1] from registered state only; there is no combinational path from ALU outputs back to these.
REQ-026 SHALL make a flag written in cycle N visible on alu_c/z_flag_in in cycle N+1, so the ADIW/SBIW second cycle sees the first-cycle C/Z.
REQ-027 SHALL drive irq_en = sreg_out[7] when SREG_SEI_DELAY_EN is undefined.

Reset
REQ-028 SHALL, with rst=1 at a clock edge, drive sreg_out=8'h00, adiw_st=0, sbiw_st=0, irq_en=0 and sei_pend=0 on the next cycle, regardless of cpuwait.
REQ-029 SHALL abort any word operation in progress on reset, with no second-cycle strobe afterwards.

Configuration
REQ-030 SHALL, when SREG_SEI_DELAY_EN is defined, set internal sei_pend for one non-stalled cycle after any I 0->1 transition, with irq_en = I & ~sei_pend; at least one instruction executes after SEI/RETI before an interrupt.
REQ-031 SHALL, with SREG_SEI_DELAY_EN defined, make an I 1->0 transition drop irq_en in the same cycle I drops and clear sei_pend.
REQ-032 SHALL, without SREG_SEI_DELAY_EN, contain no sei_pend register and follow REQ-027.

Structure
REQ-033 SHALL place the SREG bit-index constants (C=0 ... I=7) and SREG_IO_ADR default in the shared core package/include, also used by the decoder and ALU glue.
REQ-034 SHALL implement the ADIW/SBIW second-cycle sequencer as sub-module word_op_seq; all SREG logic stays in sreg_ctrl.

Verification
REQ-035 SHALL cover: flag_we=6'b000011, alu_z=1, alu_c=1 -> sreg_out=8'h03 next cycle, other bits unchanged.
REQ-036 SHALL cover: idc_adiw with cpuwait=1 for 2 cycles at the following edge -> adiw_st high 3 cycles, then low; sbiw_st stays 0.
REQ-037 SHALL cover: iowe, io_adr=6'h3F, dbus_in=8'hA5, and idc_bclr with bit_sel=0 in the same cycle -> sreg_out=8'hA5.
REQ-038 SHALL cover: I=1, then irq_ack and idc_bset with bit_sel=7 in the same cycle -> I=0, irq_en=0.
REQ-039 SHALL cover, with SREG_SEI_DELAY_EN: bset I from sreg_out=0 -> I=1, irq_en=0 for one cycle, irq_en=1 the next; without the macro irq_en=1 immediately.
REQ-040 SHALL cover: rst asserted during adiw_st with sreg_out=8'hFF -> next cycle sreg_out=8'h00, adiw_st=0, no later strobe.

Source files
------------

// File: rtl/sreg_ctrl_pkg.sv
// Shared core constants: SREG bit positions, default SREG I/O address, word-op sequencer states.
// Also used by the decoder and the ALU glue.
package sreg_ctrl_pkg;

    localparam int SREG_C = 0;
    localparam int SREG_Z = 1;
    localparam int SREG_N = 2;
    localparam int SREG_V = 3;
    localparam int SREG_S = 4;
    localparam int SREG_H = 5;
    localparam int SREG_T = 6;
    localparam int SREG_I = 7;

    localparam logic [5:0] SREG_IO_ADR_DEF = 6'h3F;

    typedef enum logic [1:0] {
        WOP_IDLE = 2'd0,
        WOP_ADIW = 2'd1,
        WOP_SBIW = 2'd2
    } wop_state_t;

    function automatic logic [7:0] sreg_bit_mask(input logic [2:0] sel);
        return 8'h01 << sel;
    endfunction

endpackage

// File: rtl/sreg_ctrl_word_op_seq.sv
// ADIW/SBIW second-cycle sequencer: one strobe cycle after the first-cycle decode.
// Latency 1 non-stalled cycle; cpuwait freezes the strobe, new requests are ignored while it is high.
module word_op_seq
    import sreg_ctrl_pkg::*;
(
    input  logic cp2,
    input  logic rst,
    input  logic cpuwait,
    input  logic idc_adiw,
    input  logic idc_sbiw,
    output logic adiw_st,
    output logic sbiw_st
);

    wop_state_t state;

    always_ff @(posedge cp2) begin
        if (rst) begin
            state   <= WOP_IDLE;
            adiw_st <= 1'b0;
            sbiw_st <= 1'b0;
        end else if (!cpuwait) begin
            case (state)
                WOP_IDLE: begin
                    // adiw takes precedence when the decoder reports both
                    if (idc_adiw) begin
                        state   <= WOP_ADIW;
                        adiw_st <= 1'b1;
                        sbiw_st <= 1'b0;
                    end else if (idc_sbiw) begin
                        state   <= WOP_SBIW;
                        adiw_st <= 1'b0;
                        sbiw_st <= 1'b1;
                    end
                end
                default: begin
                    state   <= WOP_IDLE;
                    adiw_st <= 1'b0;
                    sbiw_st <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/sreg_ctrl.sv
// Status register {I,T,H,S,V,N,Z,C} with ALU, I/O, bit-op and interrupt updates; ADIW/SBIW strobes.
// Latency 1 cycle (registered SREG); cpuwait holds all state. Optional macro: SREG_SEI_DELAY_EN.
module sreg_ctrl
    import sreg_ctrl_pkg::*;
#(
    parameter logic [5:0] SREG_IO_ADR = SREG_IO_ADR_DEF
) (
    input  logic       cp2,
    input  logic       rst,
    input  logic       cpuwait,
    input  logic       alu_h_flag_out,
    input  logic       alu_s_flag_out,
    input  logic       alu_v_flag_out,
    input  logic       alu_n_flag_out,
    input  logic       alu_z_flag_out,
    input  logic       alu_c_flag_out,
    input  logic [5:0] flag_we,
    input  logic       idc_adiw,
    input  logic       idc_sbiw,
    output logic       adiw_st,
    output logic       sbiw_st,
    output logic       alu_c_flag_in,
    output logic       alu_z_flag_in,
    input  logic [5:0] io_adr,
    input  logic       iowe,
    input  logic [7:0] dbus_in,
    output logic [7:0] sreg_out,
    input  logic       idc_bset,
    input  logic       idc_bclr,
    input  logic [2:0] bit_sel,
    input  logic       idc_bst,
    input  logic       bst_val,
    input  logic       irq_ack,
    input  logic       idc_reti,
    output logic       irq_en
);

    logic [7:0] sreg;
    logic [7:0] sreg_nxt;
    logic [7:0] upd_we;
    logic [7:0] upd_val;
    logic [7:0] sel_mask;
    logic       io_sel;

    assign upd_we   = {2'b00, flag_we};
    assign upd_val  = {2'b00, alu_h_flag_out, alu_s_flag_out, alu_v_flag_out,
                       alu_n_flag_out, alu_z_flag_out, alu_c_flag_out};
    assign sel_mask = sreg_bit_mask(bit_sel);
    assign io_sel   = iowe && (io_adr == SREG_IO_ADR);

    // Per-bit priority mux, highest source first.
    always_comb begin
        sreg_nxt = sreg;
        for (int k = 0; k < 8; k++) begin
            if (k == SREG_I && irq_ack)
                sreg_nxt[k] = 1'b0;
            else if (io_sel)
                sreg_nxt[k] = dbus_in[k];
            else if ((idc_bset || idc_bclr) && sel_mask[k])
                sreg_nxt[k] = idc_bset;
            else if (k == SREG_T && idc_bst)
                sreg_nxt[k] = bst_val;
            else if (upd_we[k])
                sreg_nxt[k] = upd_val[k];
            else if (k == SREG_I && idc_reti)
                sreg_nxt[k] = 1'b1;
        end
    end

    always_ff @(posedge cp2) begin
        if (rst)
            sreg <= 8'h00;
        else if (!cpuwait)
            sreg <= sreg_nxt;
    end

    assign sreg_out      = sreg;
    assign alu_c_flag_in = sreg[SREG_C];
    assign alu_z_flag_in = sreg[SREG_Z];

`ifdef SREG_SEI_DELAY_EN
    logic sei_pend;

    // Masks interrupts for the one instruction following an I rise; any I fall clears it.
    always_ff @(posedge cp2) begin
        if (rst)
            sei_pend <= 1'b0;
        else if (!cpuwait)
            sei_pend <= ~sreg[SREG_I] & sreg_nxt[SREG_I];
    end

    assign irq_en = sreg[SREG_I] & ~sei_pend;
`else
    assign irq_en = sreg[SREG_I];
`endif

    word_op_seq u_word_op_seq (
        .cp2      (cp2),
        .rst      (rst),
        .cpuwait  (cpuwait),
        .idc_adiw (idc_adiw),
        .idc_sbiw (idc_sbiw),
        .adiw_st  (adiw_st),
        .sbiw_st  (sbiw_st)
    );

endmodule
